// File: rtl/result_drain.sv
// Result drain for an N x N systolic array.
// Snapshots the packed result matrix on capture, then streams it out one
// row (or one column, when transposed) per beat over a valid/ready handshake.
// A one-cycle done pulse follows the last beat. The drained data is copied
// bit for bit, with no arithmetic applied.
module result_drain #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          capture,
  input  logic                                          transpose,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0]   results,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]              out_data,
  output logic [$clog2(ARRAY_SIZE)-1:0]                 out_idx,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          busy,
  output logic                                          done
);

  localparam int IDX_W = $clog2(ARRAY_SIZE);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      cnt;
  logic                  tr;
  logic [DATA_WIDTH-1:0] bank [ARRAY_SIZE][ARRAY_SIZE];

  // Control FSM plus snapshot bank; all outputs except the data mux are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tr        <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
          bank[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            // Element (0,0) sits in the MSBs of the packed matrix.
            for (int i = 0; i < ARRAY_SIZE; i++) begin
              for (int j = 0; j < ARRAY_SIZE; j++) begin
                bank[i][j] <= results[(ARRAY_SIZE*ARRAY_SIZE-(i*ARRAY_SIZE+j))*DATA_WIDTH-1 -: DATA_WIDTH];
              end
            end
            tr        <= transpose;
            cnt       <= '0;
            state     <= SEND;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          // out_valid is always high here, so out_ready alone marks a transfer.
          if (out_ready) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // capture is deliberately not looked at here; it is accepted from IDLE only.
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Beat select: row cnt of the bank, or column cnt when transposed.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      if (tr) begin
        out_data[(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH] = bank[k][cnt];
      end else begin
        out_data[(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH] = bank[cnt][k];
      end
    end
  end

  assign out_idx = cnt;

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter ARRAY_SIZE, default 4: systolic array dimension N.
REQ-002 Parameter DATA_WIDTH, default 16: bit width W of one result element.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port capture, input, 1: request to snapshot the array results; sampled only in IDLE.
REQ-006 Port transpose, input, 1: sampled with capture; 0 = drain rows, 1 = drain columns.
REQ-007 Port results, input, N*N*W: packed result matrix, row-major; element (i,j) at bits [(N*N-(i*N+j))*W-1 -: W], so (0,0) is in the MSBs.
REQ-008 Port out_data, output, N*W: one beat = N elements; element k at bits [(N-k)*W-1 -: W].
REQ-009 Port out_idx, output, $clog2(N): row index (transpose=0) or column index (transpose=1) of the current beat.
REQ-010 Port out_valid, output, 1: out_data/out_idx hold a valid beat.
REQ-011 Port out_ready, input, 1: downstream accepts the beat.
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port done, output, 1: one-cycle pulse after the last beat transfers.

Function
REQ-014 States: IDLE, SEND, DONE.
REQ-015 IDLE, capture=1 at edge t: latch all N*N elements into an internal bank, latch transpose, clear beat counter to 0, go to SEND; out_valid=1 from cycle t+1.
REQ-016 Snapshot latency is one cycle; later changes on results do not affect the drained data.
REQ-017 SEND: out_data = bank row[cnt] (transpose=0) or bank column[cnt] (transpose=1); out_idx = cnt; out_valid = 1.
REQ-018 A transfer occurs at an edge where out_valid=1 and out_ready=1; cnt then increments by 1.
REQ-019 If out_ready=0, out_data, out_idx and out_valid hold unchanged; out_valid never drops before its transfer.
REQ-020 A transfer with cnt=N-1: go to DONE, out_valid=0 the next cycle; no wrap to beat 0.
REQ-021 DONE lasts exactly one cycle with done=1, busy=1, then returns to IDLE.
REQ-022 capture while busy=1 is ignored: no re-latch and no state change.
REQ-023 capture in the same cycle as the DONE->IDLE transition is ignored; capture is accepted from the first IDLE cycle onward.
REQ-024 Exactly N transfers occur per accepted capture; out_ready=1 continuously gives N consecutive single-cycle beats.
REQ-025 Data passes through unmodified: no arithmetic, truncation or sign handling.

Reset
REQ-026 rst=1 at an edge, in any state: state=IDLE, cnt=0, bank=0, latched transpose=0.
REQ-027 Output values after reset: out_valid=0, out_data=0, out_idx=0, busy=0, done=0.
REQ-028 rst has priority over capture and over any transfer in the same cycle.
REQ-029 rst mid-drain aborts the drain; no done pulse is produced and no further beats are presented.

Verification
REQ-030 Row drain: results = cd6f b93c 37fb e7de / 3b0d 657c 7325 455b / a107 ece9 5c21 9b4e / 11d8 26a1 5105 2650; capture=1, transpose=0, out_ready=1 -> beats 0..3 on consecutive cycles.
- Beat 0 = 64'hcd6fb93c37fbe7de, beat 3 = 64'h11d826a151052650.
- out_idx = 0,1,2,3, then done=1 for one cycle.
REQ-031 Column drain: same matrix, transpose=1 -> beat 0 = 64'hcd6f3b0da10711d8, beat 3 = 64'he7de455b9b4e2650.
REQ-032 Backpressure: out_ready=0 for 3 cycles during beat 1 -> out_data stays 64'h3b0d657c7325455b with out_idx=1 and out_valid=1; exactly 4 transfers in total; done follows the final transfer.
REQ-033 Snapshot and ignore: change results and assert capture during SEND.
- Drained data equals the original snapshot.
- No second drain starts.
- busy stays high until DONE ends.
REQ-034 Reset mid-drain: rst after beat 1 -> next cycle out_valid=0, busy=0, out_data=0, no done pulse; a new capture afterward drains from beat 0.
